// File: rtl/wallace_multiplier_pipelined_if.sv
// Operand/result bus of the pipelined Wallace multiplier.
`timescale 1ns/1ps

// Handshake: a transfer happens on a rising clk edge where valid & ready are
// both 1. A producer that raises valid keeps valid and its data stable until
// that transfer. Ready may depend combinationally on the consumer's own state
// and on the downstream ready, but never on the valid it is answering.
interface wallace_multiplier_pipelined_if #(
   parameter int WIDTH = 8,
   parameter int TAG_W = 4
);
   logic               in_valid;
   logic               in_ready;
   logic [WIDTH-1:0]   in_a;
   logic [WIDTH-1:0]   in_b;
   logic               in_signed;
   logic [TAG_W-1:0]   in_tag;
   logic               out_valid;
   logic               out_ready;
   logic [2*WIDTH-1:0] out_prod;
   logic [TAG_W-1:0]   out_tag;

   // Producer of operands and consumer of results
   modport master (
      output in_valid, in_a, in_b, in_signed, in_tag, out_ready,
      input  in_ready, out_valid, out_prod, out_tag
   );

   // Multiplier side
   modport slave (
      input  in_valid, in_a, in_b, in_signed, in_tag, out_ready,
      output in_ready, out_valid, out_prod, out_tag
   );
endinterface

// File: rtl/wallace_multiplier_pipelined.sv
// Pipelined Wallace-tree multiplier, per-transaction signed/unsigned.
// Operands are captured on acceptance, then three compute stages follow:
// partial products (Baugh-Wooley in signed mode), Wallace reduction to two
// rows, final carry-propagate add. Result appears 3 edges after acceptance.
// The whole pipeline stalls as one unit when the output is held.
`timescale 1ns/1ps

module wallace_multiplier_pipelined #(
   parameter int WIDTH = 8,
   parameter int TAG_W = 4
) (
   input  logic clk,
   input  logic rst_n,
   wallace_multiplier_pipelined_if.slave bus
);
   localparam int PW = 2 * WIDTH;
   // WIDTH partial-product rows plus one Baugh-Wooley correction row
   localparam int NR = WIDTH + 1;

   // Rows left after a number of 3:2 reduction layers
   function automatic int rows_after(input int layers);
      int n;
      n = NR;
      for (int i = 0; i < layers; i++) begin
         if (n > 2) n = 2 * (n / 3) + (n % 3);
      end
      return n;
   endfunction

   // Layers needed to reach two rows
   function automatic int num_layers();
      int n;
      int l;
      n = NR;
      l = 0;
      while (n > 2) begin
         n = 2 * (n / 3) + (n % 3);
         l++;
      end
      return l;
   endfunction

   localparam int NL = num_layers();

   logic advance;

   // Stage 0: captured operands
   logic             v0_q, v0_d;
   logic [WIDTH-1:0] a0_q, a0_d, b0_q, b0_d;
   logic             sg0_q, sg0_d;
   logic [TAG_W-1:0] tag0_q, tag0_d;

   // Stage 1: partial-product matrix
   logic             v1_q, v1_d;
   logic [PW-1:0]    pp1_q [NR];
   logic [PW-1:0]    pp1_d [NR];
   logic [TAG_W-1:0] tag1_q, tag1_d;

   // Stage 2: reduced sum and carry rows
   logic             v2_q, v2_d;
   logic [PW-1:0]    sum2_q, sum2_d, carry2_q, carry2_d;
   logic [TAG_W-1:0] tag2_q, tag2_d;

   // Stage 3: final product
   logic             v3_q, v3_d;
   logic [PW-1:0]    prod3_q, prod3_d;
   logic [TAG_W-1:0] tag3_q, tag3_d;

   logic [PW-1:0]    pp_gen [NR];
   logic [PW-1:0]    red_sum, red_carry;

   assign advance = ~v3_q | bus.out_ready;

   // Partial products; in signed mode the terms pairing exactly one MSB are
   // complemented and bits WIDTH and 2*WIDTH-1 of the correction row are set
   always_comb begin
      for (int i = 0; i < NR; i++) pp_gen[i] = '0;
      for (int i = 0; i < WIDTH; i++) begin
         for (int j = 0; j < WIDTH; j++) begin
            pp_gen[i][i+j] = (a0_q[j] & b0_q[i]) ^
                             (sg0_q & ((i == WIDTH - 1) != (j == WIDTH - 1)));
         end
      end
      if (sg0_q) begin
         pp_gen[WIDTH][WIDTH]  = 1'b1;
         pp_gen[WIDTH][PW-1]   = 1'b1;
      end
   end

   // Wallace reduction: each layer compresses row triples with full adders
   // (sum row plus carry row shifted left); leftover rows pass straight on.
   // Carries out of bit PW-1 are dropped since the product fits in PW bits.
   for (genvar l = 0; l < NL; l++) begin : g_layer
      localparam int NI = rows_after(l);
      localparam int NO = rows_after(l + 1);
      localparam int NG = NI / 3;
      logic [PW-1:0] src [NI];
      logic [PW-1:0] dst [NO];
      if (l == 0) begin : g_first
         assign src = pp1_q;
      end else begin : g_next
         assign src = g_layer[l-1].dst;
      end
      for (genvar g = 0; g < NG; g++) begin : g_fa
         assign dst[2*g]   = src[3*g] ^ src[3*g+1] ^ src[3*g+2];
         assign dst[2*g+1] = ((src[3*g] & src[3*g+1]) |
                              (src[3*g] & src[3*g+2]) |
                              (src[3*g+1] & src[3*g+2])) << 1;
      end
      for (genvar r = 3 * NG; r < NI; r++) begin : g_pass
         assign dst[2*NG + r - 3*NG] = src[r];
      end
   end

   assign red_sum   = g_layer[NL-1].dst[0];
   assign red_carry = g_layer[NL-1].dst[1];

   // Next-state for every stage; all stages hold together when not advancing
   always_comb begin
      v0_d     = v0_q;
      a0_d     = a0_q;
      b0_d     = b0_q;
      sg0_d    = sg0_q;
      tag0_d   = tag0_q;
      v1_d     = v1_q;
      pp1_d    = pp1_q;
      tag1_d   = tag1_q;
      v2_d     = v2_q;
      sum2_d   = sum2_q;
      carry2_d = carry2_q;
      tag2_d   = tag2_q;
      v3_d     = v3_q;
      prod3_d  = prod3_q;
      tag3_d   = tag3_q;
      if (advance) begin
         // Bubbles carry zero operands so idle stages hold clean values
         v0_d     = bus.in_valid;
         a0_d     = bus.in_valid ? bus.in_a      : '0;
         b0_d     = bus.in_valid ? bus.in_b      : '0;
         sg0_d    = bus.in_valid ? bus.in_signed : 1'b0;
         tag0_d   = bus.in_valid ? bus.in_tag    : '0;
         v1_d     = v0_q;
         pp1_d    = pp_gen;
         tag1_d   = tag0_q;
         v2_d     = v1_q;
         sum2_d   = red_sum;
         carry2_d = red_carry;
         tag2_d   = tag1_q;
         v3_d     = v2_q;
         prod3_d  = sum2_q + carry2_q;
         tag3_d   = tag2_q;
      end
   end

   // Pipeline registers; reset discards everything in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v0_q     <= 1'b0;
         a0_q     <= '0;
         b0_q     <= '0;
         sg0_q    <= 1'b0;
         tag0_q   <= '0;
         v1_q     <= 1'b0;
         for (int i = 0; i < NR; i++) pp1_q[i] <= '0;
         tag1_q   <= '0;
         v2_q     <= 1'b0;
         sum2_q   <= '0;
         carry2_q <= '0;
         tag2_q   <= '0;
         v3_q     <= 1'b0;
         prod3_q  <= '0;
         tag3_q   <= '0;
      end else begin
         v0_q     <= v0_d;
         a0_q     <= a0_d;
         b0_q     <= b0_d;
         sg0_q    <= sg0_d;
         tag0_q   <= tag0_d;
         v1_q     <= v1_d;
         pp1_q    <= pp1_d;
         tag1_q   <= tag1_d;
         v2_q     <= v2_d;
         sum2_q   <= sum2_d;
         carry2_q <= carry2_d;
         tag2_q   <= tag2_d;
         v3_q     <= v3_d;
         prod3_q  <= prod3_d;
         tag3_q   <= tag3_d;
      end
   end

   assign bus.in_ready  = advance;
   assign bus.out_valid = v3_q;
   assign bus.out_prod  = prod3_q;
   assign bus.out_tag   = tag3_q;
endmodule
